cape_sched: RTL and testbench
=============================

# cape_sched

Job controller for the CAPE stochastic bitstream generator. It accepts one SC evaluation job at a time over a valid/ready request channel and holds that job's binary operands and truncation mask. It clears and enables the generator, then counts the output ones of the downstream SC circuit for either a programmed cycle budget (early termination) or a full generator period. The result is returned on a valid/ready response channel. It sits between the host/accelerator command path and the generator plus SC-circuit datapath.

## Interface
- WIDTH, 8, bit width of each binary operand
- NUM_INPUTS, 4, number of operands / generated bitstreams
- LEN_W, 16, width of cycle budget and result counters
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  job request valid
- req_ready  out  1  controller can accept a job
- req_bxs  in  WIDTH*NUM_INPUTS  operands, operand i at bits [i*WIDTH +: WIDTH]
- req_trunc  in  WIDTH  truncation mask forwarded to generator
- req_len  in  LEN_W  cycle budget; 0 = run until gen_last
- abort  in  1  synchronous job kill
- gen_bxs  out  WIDTH*NUM_INPUTS  registered operands to generator
- gen_trunc  out  WIDTH  registered mask to generator
- gen_clr  out  1  synchronous generator counter clear
- gen_en  out  1  generator advance enable
- gen_last  in  1  current enabled cycle is the last of the generator period
- sc_bit  in  1  SC circuit output for current cycle (combinational from generator outputs)
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result consumed
- rsp_ones  out  LEN_W  count of sc_bit==1 over the run
- rsp_cycles  out  LEN_W  number of run cycles
- rsp_early  out  1  run ended by budget before gen_last
- rsp_sat  out  1  a counter saturated

## Operation
- States IDLE, CLEAR, RUN, RESP.
- IDLE: req_ready=1. On req_valid, capture req_bxs/req_trunc/req_len into gen_bxs/gen_trunc/len_q → CLEAR.
- CLEAR: gen_clr=1 for exactly one cycle; ones, cycles and flags zeroed → RUN.
- RUN: gen_en=1 each cycle. Per cycle: cycles += 1; ones += sc_bit. Both saturate at 2^LEN_W-1; rsp_sat is set sticky on any saturation.
- RUN exit on the cycle where gen_last=1 or (len_q!=0 and cycles+1==len_q). The exit cycle itself is counted. rsp_early=1 iff the budget condition alone fired. If both fire, rsp_early=0.
- If len_q==0 and cycles saturates before gen_last, the run continues until gen_last; rsp_sat=1.
- RESP: rsp_valid=1, results stable. On rsp_ready → IDLE. req_ready=0 outside IDLE.
- abort=1 in CLEAR/RUN/RESP → IDLE next cycle. No response is produced; an abort in RESP drops the pending result. abort has no effect in IDLE. abort has priority over all exits.
- gen_en=0 and gen_clr=0 in IDLE and RESP; the generator holds state.

## Timing
- Reset: state=IDLE, req_ready=1, gen_en=0, gen_clr=0, rsp_valid=0; all result, flag and operand registers 0.
- Request accepted at edge T0 (req_valid & req_ready). CLEAR during T0+1. RUN during T0+2 … T0+L+1 for L run cycles. rsp_valid high from T0+L+2.
- Minimum turnaround: a new request is accepted no earlier than the cycle after the rsp handshake.
- Outputs are registered or decoded from state only. There is no combinational path from req_* or rsp_ready to outputs, except req_ready = (state==IDLE).
- len_q==1: exactly one RUN cycle, rsp_cycles=1.

## Structure
- Package cape_sched_pkg: state enum type, LEN_W default, and a localparam for the saturating maximum.
- One sub-module, sat_ctr (LEN_W-bit clear/increment counter with saturation flag), instantiated twice for ones and cycles.

## Test plan
- Reset mid-RUN (rst_n low at T0+5) -> immediate IDLE, rsp_valid=0, gen_en=0, req_ready=1.
- req_len=10, sc_bit high on 4 of 10 RUN cycles -> rsp_cycles=10, rsp_ones=4, rsp_early=1; rsp_valid at T0+12.
- req_len=0, gen_last on 256th RUN cycle, sc_bit always 1 -> rsp_cycles=256, rsp_ones=256, rsp_early=0, rsp_sat=0.
- req_len=8 with gen_last also on 8th cycle -> rsp_early=0; gen_clr high only at T0+1.
- LEN_W=4, req_len=0, gen_last at cycle 20, sc_bit=1 -> rsp_cycles=15, rsp_ones=15, rsp_sat=1.
- abort during RUN, then a new request of len 3 -> no rsp for the first job; second gives rsp_cycles=3. rsp_ready held low 5 cycles -> rsp_valid and data stable throughout.

Source files
------------

// File: rtl/cape_sched_pkg.sv
// cape_sched_pkg: shared types and constants for the CAPE job controller.
//   state_e     - controller FSM states
//   LenWDefault - default width of the cycle budget and result counters
//   SatMax      - saturating maximum of a default-width counter
package cape_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StRun,
    StResp
  } state_e;

  localparam int unsigned LenWDefault = 16;
  localparam logic [LenWDefault-1:0] SatMax = '1;

endpackage

// File: rtl/cape_sched_if.sv
// cape_sched_if: job request / result response channels of the CAPE job controller.
//   req_* : host -> controller job request (valid/ready), operands, mask, cycle budget
//   rsp_* : controller -> host result (valid/ready), ones count, run cycles, flags
//   master: host side, slave: controller side
interface cape_sched_if
  import cape_sched_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned LEN_W      = LenWDefault
);

  logic                        req_valid;
  logic                        req_ready;
  logic [WIDTH*NUM_INPUTS-1:0] req_bxs;
  logic [WIDTH-1:0]            req_trunc;
  logic [LEN_W-1:0]            req_len;

  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [LEN_W-1:0]            rsp_ones;
  logic [LEN_W-1:0]            rsp_cycles;
  logic                        rsp_early;
  logic                        rsp_sat;

  modport master (
    output req_valid, req_bxs, req_trunc, req_len, rsp_ready,
    input  req_ready, rsp_valid, rsp_ones, rsp_cycles, rsp_early, rsp_sat
  );

  modport slave (
    input  req_valid, req_bxs, req_trunc, req_len, rsp_ready,
    output req_ready, rsp_valid, rsp_ones, rsp_cycles, rsp_early, rsp_sat
  );

endinterface

// File: rtl/cape_sched_sat_ctr.sv
// sat_ctr: clearable incrementing counter that sticks at its maximum.
//   clk_i, rst_ni - clock, async active-low reset
//   clr_i         - synchronous clear (wins over inc_i)
//   inc_i         - increment request
//   cnt_o         - current count
//   sat_o         - an increment is being dropped because the count is at its maximum
module sat_ctr
  import cape_sched_pkg::*;
#(
  parameter int unsigned Width = LenWDefault
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o,
  output logic             sat_o
);

  localparam logic [Width-1:0] Max = '1;

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != Max)) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  // Reaching Max is fine; only a lost increment counts as saturation.
  assign sat_o = inc_i && (cnt_q == Max);

endmodule

// File: rtl/cape_sched.sv
// cape_sched: job controller for the CAPE stochastic bitstream generator.
//   clk, rst_n          - clock, async active-low reset
//   bus (slave)         - job request / result response channels
//   abort               - synchronous job kill (ignored when idle)
//   gen_bxs, gen_trunc  - captured operands and truncation mask for the generator
//   gen_clr, gen_en     - generator clear (one cycle before the run) and advance enable
//   gen_last            - generator period ends on this enabled cycle
//   sc_bit              - SC circuit output bit for the current run cycle
module cape_sched
  import cape_sched_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned LEN_W      = LenWDefault
) (
  input  logic                        clk,
  input  logic                        rst_n,
  cape_sched_if.slave                 bus,
  input  logic                        abort,
  output logic [WIDTH*NUM_INPUTS-1:0] gen_bxs,
  output logic [WIDTH-1:0]            gen_trunc,
  output logic                        gen_clr,
  output logic                        gen_en,
  input  logic                        gen_last,
  input  logic                        sc_bit
);

  state_e                      state_q, state_d;
  logic [WIDTH*NUM_INPUTS-1:0] bxs_q, bxs_d;
  logic [WIDTH-1:0]            trunc_q, trunc_d;
  logic [LEN_W-1:0]            len_q, len_d;
  logic                        early_q, early_d;
  logic                        sat_q, sat_d;

  logic             in_run, in_clear;
  logic [LEN_W-1:0] ones_cnt, cyc_cnt;
  logic             ones_sat, cyc_sat;
  logic [LEN_W:0]   cyc_next;
  logic             budget_hit;

  assign in_run   = (state_q == StRun);
  assign in_clear = (state_q == StClear);

  sat_ctr #(
    .Width (LEN_W)
  ) u_ones_ctr (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clr_i  (in_clear),
    .inc_i  (in_run & sc_bit),
    .cnt_o  (ones_cnt),
    .sat_o  (ones_sat)
  );

  sat_ctr #(
    .Width (LEN_W)
  ) u_cyc_ctr (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clr_i  (in_clear),
    .inc_i  (in_run),
    .cnt_o  (cyc_cnt),
    .sat_o  (cyc_sat)
  );

  // One extra bit so a saturated cycle count cannot wrap into a false budget match.
  assign cyc_next   = {1'b0, cyc_cnt} + (LEN_W + 1)'(1);
  assign budget_hit = (len_q != '0) && (cyc_next == {1'b0, len_q});

  always_comb begin
    state_d = state_q;
    bxs_d   = bxs_q;
    trunc_d = trunc_q;
    len_d   = len_q;
    early_d = early_q;
    sat_d   = sat_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          bxs_d   = bus.req_bxs;
          trunc_d = bus.req_trunc;
          len_d   = bus.req_len;
          state_d = StClear;
        end
      end
      StClear: begin
        early_d = 1'b0;
        sat_d   = 1'b0;
        state_d = StRun;
      end
      StRun: begin
        sat_d = sat_q | ones_sat | cyc_sat;
        if (gen_last || budget_hit) begin
          // Early only when the budget ends the run before the generator period does.
          early_d = budget_hit & ~gen_last;
          state_d = StResp;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      bxs_q   <= '0;
      trunc_q <= '0;
      len_q   <= '0;
      early_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bxs_q   <= bxs_d;
      trunc_q <= trunc_d;
      len_q   <= len_d;
      early_q <= early_d;
      sat_q   <= sat_d;
    end
  end

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.rsp_valid  = (state_q == StResp);
  assign bus.rsp_ones   = ones_cnt;
  assign bus.rsp_cycles = cyc_cnt;
  assign bus.rsp_early  = early_q;
  assign bus.rsp_sat    = sat_q;
  assign gen_bxs        = bxs_q;
  assign gen_trunc      = trunc_q;
  assign gen_clr        = in_clear;
  assign gen_en         = in_run;

endmodule

// File: tb/tb_cape_sched.sv
// tb_cape_sched: randomized and directed jobs on a 16-bit and a 4-bit counter instance,
// each result compared with a job-level reference computed from the run plan.
module tb_cape_sched;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        sel;  // 0: 16-bit instance, 1: 4-bit instance
  logic        req_valid, rsp_ready, abort, gen_last, sc_bit;
  logic [31:0] req_bxs;
  logic [7:0]  req_trunc;
  logic [15:0] req_len;

  int n_checks = 0;
  int n_fail   = 0;

  cape_sched_if #(.WIDTH(8), .NUM_INPUTS(4), .LEN_W(16)) ifa ();
  cape_sched_if #(.WIDTH(8), .NUM_INPUTS(4), .LEN_W(4))  ifb ();

  assign ifa.req_valid = req_valid & ~sel;
  assign ifb.req_valid = req_valid & sel;
  assign ifa.req_bxs   = req_bxs;
  assign ifb.req_bxs   = req_bxs;
  assign ifa.req_trunc = req_trunc;
  assign ifb.req_trunc = req_trunc;
  assign ifa.req_len   = req_len;
  assign ifb.req_len   = req_len[3:0];
  assign ifa.rsp_ready = rsp_ready;
  assign ifb.rsp_ready = rsp_ready;

  logic [31:0] bxs_a, bxs_b;
  logic [7:0]  trunc_a, trunc_b;
  logic        clr_a, clr_b, en_a, en_b;

  cape_sched #(.WIDTH(8), .NUM_INPUTS(4), .LEN_W(16)) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (ifa),
    .abort     (abort),
    .gen_bxs   (bxs_a),
    .gen_trunc (trunc_a),
    .gen_clr   (clr_a),
    .gen_en    (en_a),
    .gen_last  (gen_last),
    .sc_bit    (sc_bit)
  );

  cape_sched #(.WIDTH(8), .NUM_INPUTS(4), .LEN_W(4)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (ifb),
    .abort     (abort),
    .gen_bxs   (bxs_b),
    .gen_trunc (trunc_b),
    .gen_clr   (clr_b),
    .gen_en    (en_b),
    .gen_last  (gen_last),
    .sc_bit    (sc_bit)
  );

  // Outputs of whichever instance is under test.
  logic        o_req_ready, o_rsp_valid, o_early, o_sat, o_clr, o_en;
  logic [15:0] o_ones, o_cycles;
  logic [31:0] o_bxs;
  logic [7:0]  o_trunc;
  assign o_req_ready = sel ? ifb.req_ready : ifa.req_ready;
  assign o_rsp_valid = sel ? ifb.rsp_valid : ifa.rsp_valid;
  assign o_early     = sel ? ifb.rsp_early : ifa.rsp_early;
  assign o_sat       = sel ? ifb.rsp_sat : ifa.rsp_sat;
  assign o_ones      = sel ? {12'd0, ifb.rsp_ones} : ifa.rsp_ones;
  assign o_cycles    = sel ? {12'd0, ifb.rsp_cycles} : ifa.rsp_cycles;
  assign o_clr       = sel ? clr_b : clr_a;
  assign o_en        = sel ? en_b : en_a;
  assign o_bxs       = sel ? bxs_b : bxs_a;
  assign o_trunc     = sel ? trunc_b : trunc_a;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_req_ready"}, o_req_ready, 1);
    check_eq({tag, "_rsp_valid"}, o_rsp_valid, 0);
    check_eq({tag, "_gen_en"}, o_en, 0);
    check_eq({tag, "_gen_clr"}, o_clr, 0);
  endtask

  // One job, entered and left at a falling edge.
  //   sc_mode: 0 random sc_bit, 1 always 1, 2 bit k-1 of pat on run cycle k
  //   g: run cycle carrying gen_last; abort_at: run cycle to abort on (-1: in RESP)
  //   reset_at: run cycle to pulse rst_n on; rdly: cycles rsp_ready is held low
  task automatic run_job(input int len, input int g, input int sc_mode, input logic [63:0] pat,
                         input int rdly, input int abort_at, input int reset_at);
    int          maxv, l_ref, ones, exp_ones, exp_cyc;
    bit          early_ref, sat_ref, b;
    logic [31:0] exp_bxs;
    logic [7:0]  exp_trunc;
    maxv      = sel ? 15 : 65535;
    early_ref = (len != 0) && (len < g);
    l_ref     = early_ref ? len : g;
    ones      = 0;

    check_eq("idle_req_ready", o_req_ready, 1);
    exp_bxs   = $urandom;
    exp_trunc = 8'($urandom);
    req_valid = 1'b1;
    req_bxs   = exp_bxs;
    req_trunc = exp_trunc;
    req_len   = 16'(len);
    abort     = ($urandom_range(0, 3) == 0);  // must be ignored while idle
    @(negedge clk);
    req_valid = 1'b0;
    abort     = 1'b0;
    req_bxs   = $urandom;
    req_trunc = 8'($urandom);
    req_len   = 16'($urandom);
    check_eq("clear_gen_clr", o_clr, 1);
    check_eq("clear_gen_en", o_en, 0);
    check_eq("clear_req_ready", o_req_ready, 0);
    check_eq("clear_gen_bxs", o_bxs, exp_bxs);
    check_eq("clear_gen_trunc", o_trunc, exp_trunc);
    @(negedge clk);

    for (int k = 1; k <= l_ref; k++) begin
      check_eq("run_gen_en", o_en, 1);
      check_eq("run_gen_clr", o_clr, 0);
      check_eq("run_rsp_valid", o_rsp_valid, 0);
      if (sc_mode == 1) b = 1'b1;
      else if (sc_mode == 2) b = (k <= 64) ? pat[k-1] : 1'b0;
      else b = 1'($urandom);
      sc_bit   = b;
      ones    += int'(b);
      gen_last = (k == g);
      if (k == abort_at) abort = 1'b1;
      if (k == reset_at) begin
        rst_n = 1'b0;
        #1;
        check_idle_outputs("reset");
        check_eq("reset_ones", o_ones, 0);
        check_eq("reset_cycles", o_cycles, 0);
        check_eq("reset_bxs", o_bxs, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        sc_bit   = 1'b0;
        gen_last = 1'b0;
        return;
      end
      @(negedge clk);
      sc_bit   = 1'b0;
      gen_last = 1'b0;
      abort    = 1'b0;
      if (k == abort_at) begin
        check_idle_outputs("abort_run");
        return;
      end
    end

    exp_cyc  = (l_ref > maxv) ? maxv : l_ref;
    exp_ones = (ones > maxv) ? maxv : ones;
    sat_ref  = (l_ref > maxv) || (ones > maxv);
    for (int d = 0; d <= rdly; d++) begin
      check_eq("rsp_valid", o_rsp_valid, 1);
      check_eq("rsp_cycles", o_cycles, exp_cyc);
      check_eq("rsp_ones", o_ones, exp_ones);
      check_eq("rsp_early", o_early, early_ref);
      check_eq("rsp_sat", o_sat, sat_ref);
      check_eq("rsp_gen_en", o_en, 0);
      check_eq("rsp_gen_clr", o_clr, 0);
      check_eq("rsp_req_ready", o_req_ready, 0);
      check_eq("rsp_gen_bxs", o_bxs, exp_bxs);
      if (abort_at < 0) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_idle_outputs("abort_resp");
        return;
      end
      if (d == rdly) rsp_ready = 1'b1;
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    check_idle_outputs("after_rsp");
  endtask

  initial begin
    int len, g, rdly, ab;
    sel       = 1'b0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    abort     = 1'b0;
    gen_last  = 1'b0;
    sc_bit    = 1'b0;
    req_bxs   = '0;
    req_trunc = '0;
    req_len   = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      check_idle_outputs("por");
      check_eq("por_ones", o_ones, 0);
      check_eq("por_cycles", o_cycles, 0);
      check_eq("por_early", o_early, 0);
      check_eq("por_sat", o_sat, 0);
      check_eq("por_bxs", o_bxs, 0);
      check_eq("por_trunc", o_trunc, 0);
    end
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    run_job(10, 200, 2, 64'h129, 0, 0, 0);   // 4 ones in 10 budgeted cycles
    run_job(0, 256, 1, 64'h0, 0, 0, 0);      // full period, all ones
    run_job(8, 8, 0, 64'h0, 1, 0, 0);        // budget and gen_last together
    run_job(1, 50, 0, 64'h0, 0, 0, 0);       // single run cycle
    run_job(0, 50, 0, 64'h0, 0, 6, 0);       // abort mid-run
    run_job(3, 50, 0, 64'h0, 5, 0, 0);       // then a fresh job, slow consumer
    run_job(4, 50, 0, 64'h0, 2, -1, 0);      // abort drops a pending result
    run_job(0, 100, 0, 64'h0, 0, 0, 4);      // reset at T0+5
    run_job(6, 9, 0, 64'h0, 0, 0, 0);

    for (int i = 0; i < 25; i++) begin
      len  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 20));
      g    = int'($urandom_range(1, 30));
      rdly = int'($urandom_range(0, 3));
      ab   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 10)) : 0;
      run_job(len, g, 0, 64'h0, rdly, ab, 0);
    end

    sel = 1'b1;
    run_job(0, 20, 1, 64'h0, 0, 0, 0);       // counters saturate at 15
    run_job(5, 20, 0, 64'h0, 1, 0, 0);
    run_job(0, 9, 0, 64'h0, 0, 0, 0);
    run_job(12, 16, 1, 64'h0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
